memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register index width.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM entry holds a valid instruction.
- ex_alu_result  in  XLEN  ALU result or effective address.
- ex_rs2_data  in  XLEN  store data.
- ex_pc_plus4  in  XLEN  link value.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_funct3  in  3  access size and sign.
- ex_wb_sel  in  2  result select: 00 ALU, 01 load, 10 pc+4.
- mem_stall  out  1  hold EX/MEM and all earlier stages.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  XLEN  word-aligned address, low 2 bits 0.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  request accepted/completed; rdata valid.
- dmem_rdata  in  XLEN  read word.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rd  out  REG_AW  destination register.
- wb_reg_write  out  1  register-file write enable.
- wb_data  out  XLEN  final writeback value.
- wb_misaligned  out  1  misaligned-access flag, registered with the entry.

Function
REQ-004 SHALL implement FSM states IDLE and WAIT.
REQ-005 A memory op is ex_valid AND (ex_mem_read OR ex_mem_write).
REQ-006 Non-memory ops, and aligned memory ops acked in the same cycle, SHALL reach the MEM/WB register one cycle later (latency 1).
REQ-007 In IDLE, an aligned memory op SHALL drive dmem_req=1 combinationally from the ex_* inputs; if dmem_ack=0, it SHALL latch the address, data, be, we, rd, funct3 and control into internal registers and go to WAIT.
REQ-008 In WAIT, dmem_* SHALL be driven only from the latched registers and dmem_req SHALL stay 1 until dmem_ack.
REQ-009 On dmem_ack in WAIT, the entry SHALL be written to MEM/WB and the FSM SHALL return to IDLE.
REQ-010 mem_stall = (IDLE AND aligned memory op AND NOT dmem_ack) OR WAIT.
REQ-011 While mem_stall is high, the MEM/WB register SHALL load a bubble: wb_valid=0, wb_reg_write=0.
REQ-012 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=00.
REQ-013 A misaligned op SHALL issue no dmem_req and no stall, and SHALL write MEM/WB with wb_valid=1, wb_misaligned=1 and wb_reg_write=0.
REQ-014 Store funct3 encoding: 000 SB with be=0001<<addr[1:0], data byte replicated x4; 001 SH with be=0011<<addr[1:0], data halfword replicated x2; 010 SW with be=1111.
REQ-015 For loads, dmem_be=1111 and dmem_we=0.
REQ-016 Load funct3 encoding: 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW; the lane SHALL be selected by addr[1:0].
REQ-017 wb_data SHALL be selected by wb_sel: ALU result, aligned load result, or pc+4.
REQ-018 Undefined funct3 values SHALL behave as word access.
REQ-019 wb_reg_write SHALL equal ex_reg_write AND valid AND NOT misaligned AND rd!=0.
REQ-020 ex_valid=0 SHALL produce a bubble and SHALL NOT issue dmem_req.
REQ-021 Upstream changes to the ex_* inputs during WAIT SHALL have no effect.

Reset
REQ-022 With rst=1 at a clock edge: FSM to IDLE; wb_valid, wb_reg_write and wb_misaligned to 0; wb_rd and wb_data to 0.
REQ-023 With rst=1, dmem_req and mem_stall SHALL be 0 combinationally.
REQ-024 Reset while in WAIT SHALL abandon the request; a subsequent dmem_ack in IDLE with no request SHALL be ignored.

Structure
REQ-025 funct3 codes, wb_sel codes and FSM state encodings SHALL live in shared package rv_pkg.
REQ-026 Load extraction and extension SHALL be sub-module load_align (inputs rdata, addr[1:0], funct3; output XLEN result).

Verification
REQ-027 ADD result 0x0000_0010, rd=5, wb_sel=00 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, no dmem_req.
REQ-028 LB at addr 0x103, rdata=0x80FF_FF7F, ack same cycle -> wb_data=0xFFFF_FF80; LBU at the same address -> wb_data=0x0000_0080.
REQ-029 SH at addr 0x202, rs2=0x1234_ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1, wb_reg_write=0.
REQ-030 LW at addr 0x40, ack after 3 cycles -> mem_stall high 3 cycles, 3 bubbles, then wb_data=rdata; ex_* inputs changed during WAIT are ignored.
REQ-031 LW at addr 0x41 -> no dmem_req, wb_misaligned=1, wb_reg_write=0 next cycle.
REQ-032 rst asserted in WAIT -> next cycle IDLE, dmem_req=0, wb_valid=0; a late dmem_ack produces no writeback.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV encodings for the memory stage: funct3 codes, writeback selects,
// FSM state encodings and access-size helpers.
package rv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_t;

   // Unsigned byte/half codes exist only for loads; anything undefined is a word.
   function automatic acc_size_t acc_size(input logic [2:0] f3, input logic is_load);
      if (f3 == F3_B || (is_load && f3 == F3_BU))
         return SZ_B;
      else if (f3 == F3_H || (is_load && f3 == F3_HU))
         return SZ_H;
      else
         return SZ_W;
   endfunction

   function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] off);
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input acc_size_t sz, input logic [1:0] off);
      case (sz)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword lane from a read word and extends it.
module load_align
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[7:0];
      case (addr)
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         2'd3:    byte_v = rdata[31:24];
         default: byte_v = rdata[7:0];
      endcase
      half_v = addr[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
         F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
         F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// RV pipeline MEM stage: data-memory handshake with a one-entry wait buffer,
// store lane formatting, load alignment and the MEM/WB register.
module memory_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_alu_result,
   input  logic [XLEN-1:0]   ex_rs2_data,
   input  logic [XLEN-1:0]   ex_pc_plus4,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [2:0]        ex_funct3,
   input  logic [1:0]        ex_wb_sel,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_reg_write,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_misaligned
);

   logic [0:0]        state_q, state_d;

   acc_size_t         ex_sz;
   logic              mem_op, ex_mis, aligned_op;
   logic [3:0]        ex_be;
   logic [XLEN-1:0]   ex_wdata, ex_addr_w;

   logic [XLEN-1:0]   lat_addr, lat_wdata, lat_alu, lat_pc4;
   logic [3:0]        lat_be;
   logic              lat_we, lat_reg_write;
   logic [REG_AW-1:0] lat_rd;
   logic [2:0]        lat_f3;
   logic [1:0]        lat_off, lat_wb_sel;

   logic [2:0]        cur_f3;
   logic [1:0]        cur_off, cur_wb_sel;
   logic [XLEN-1:0]   cur_alu, cur_pc4, load_data, wb_data_d;

   // Request decode from the EX/MEM entry; a set mem_write wins over mem_read.
   always_comb begin
      mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
      ex_sz      = acc_size(ex_funct3, ~ex_mem_write);
      ex_mis     = mem_op & is_misaligned(ex_sz, ex_alu_result[1:0]);
      aligned_op = mem_op & ~ex_mis;
      ex_addr_w  = {ex_alu_result[XLEN-1:2], 2'b00};
      ex_be      = ex_mem_write ? store_be(ex_sz, ex_alu_result[1:0]) : 4'b1111;
      case (ex_sz)
         SZ_B:    ex_wdata = {(XLEN/8){ex_rs2_data[7:0]}};
         SZ_H:    ex_wdata = {(XLEN/16){ex_rs2_data[15:0]}};
         default: ex_wdata = ex_rs2_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_stall  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = ex_mem_write;
      dmem_addr  = ex_addr_w;
      dmem_wdata = ex_wdata;
      dmem_be    = ex_be;
      case (state_q)
         ST_WAIT: begin
            dmem_req   = 1'b1;
            mem_stall  = 1'b1;
            dmem_we    = lat_we;
            dmem_addr  = lat_addr;
            dmem_wdata = lat_wdata;
            dmem_be    = lat_be;
            if (dmem_ack) state_d = ST_IDLE;
         end
         default: begin
            dmem_req  = aligned_op;
            mem_stall = aligned_op & ~dmem_ack;
            if (aligned_op && !dmem_ack) state_d = ST_WAIT;
         end
      endcase
      if (rst) begin
         dmem_req  = 1'b0;
         mem_stall = 1'b0;
      end
   end

   // Wait buffer: captures the whole entry so upstream may change during WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_addr      <= '0;
         lat_wdata     <= '0;
         lat_alu       <= '0;
         lat_pc4       <= '0;
         lat_be        <= '0;
         lat_we        <= 1'b0;
         lat_reg_write <= 1'b0;
         lat_rd        <= '0;
         lat_f3        <= '0;
         lat_off       <= '0;
         lat_wb_sel    <= '0;
      end else if (state_q == ST_IDLE && aligned_op && !dmem_ack) begin
         lat_addr      <= ex_addr_w;
         lat_wdata     <= ex_wdata;
         lat_alu       <= ex_alu_result;
         lat_pc4       <= ex_pc_plus4;
         lat_be        <= ex_be;
         lat_we        <= ex_mem_write;
         lat_reg_write <= ex_reg_write & (ex_rd != '0);
         lat_rd        <= ex_rd;
         lat_f3        <= ex_funct3;
         lat_off       <= ex_alu_result[1:0];
         lat_wb_sel    <= ex_wb_sel;
      end
   end

   always_comb begin
      cur_f3     = ex_funct3;
      cur_off    = ex_alu_result[1:0];
      cur_wb_sel = ex_wb_sel;
      cur_alu    = ex_alu_result;
      cur_pc4    = ex_pc_plus4;
      if (state_q == ST_WAIT) begin
         cur_f3     = lat_f3;
         cur_off    = lat_off;
         cur_wb_sel = lat_wb_sel;
         cur_alu    = lat_alu;
         cur_pc4    = lat_pc4;
      end
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata  (dmem_rdata),
      .addr   (cur_off),
      .funct3 (cur_f3),
      .result (load_data)
   );

   always_comb begin
      case (cur_wb_sel)
         WB_LOAD: wb_data_d = load_data;
         WB_PC4:  wb_data_d = cur_pc4;
         default: wb_data_d = cur_alu;
      endcase
   end

   // MEM/WB register: completed wait entry, bubble while stalled, else the EX entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid      <= 1'b0;
         wb_rd         <= '0;
         wb_reg_write  <= 1'b0;
         wb_data       <= '0;
         wb_misaligned <= 1'b0;
      end else if (state_q == ST_WAIT && dmem_ack) begin
         wb_valid      <= 1'b1;
         wb_rd         <= lat_rd;
         wb_reg_write  <= lat_reg_write;
         wb_data       <= wb_data_d;
         wb_misaligned <= 1'b0;
      end else if (mem_stall) begin
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_misaligned <= 1'b0;
      end else begin
         wb_valid      <= ex_valid;
         wb_rd         <= ex_rd;
         wb_reg_write  <= ex_reg_write & ex_valid & ~ex_mis & (ex_rd != '0);
         wb_data       <= wb_data_d;
         wb_misaligned <= ex_mis;
      end
   end

endmodule
